// File: rtl/suu_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// hold-vector encodings, stage bit positions and divide-sequencer states.
package suu_pipe_ctrl_pkg;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    // Each encoding holds a contiguous run of stages starting at the PC.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_DIV_RUN  = 2'b01,
        ST_DIV_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/suu_div_seq.sv
// Iterative-divider sequencer: issues the start pulse, counts the divide
// latency, presents done until EX is free to capture, and annuls on flush.
module suu_div_seq
    import suu_pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       div_req,
    input  logic       flush_req,
    input  logic       hold_ex,
    output div_state_e state,
    output logic       div_start,
    output logic       div_annul,
    output logic       div_done,
    output logic       div_busy
);

    div_state_e             state_r;
    div_state_e             state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;

    // State and counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter update; a flush overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (flush_req) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (div_req) begin
                        state_nxt_s = ST_DIV_RUN;
                        cnt_nxt_s   = CNT_W'(DIV_CYCLES - 1);
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DIV_RUN: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_nxt_s = ST_DIV_DONE;
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_W'(1);
                    end
                end
                ST_DIV_DONE: begin
                    // Stay put while EX is held so the finished divide is not reissued.
                    if (hold_ex) begin
                        state_nxt_s = ST_DIV_DONE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign state     = state_r;
    assign div_start = (state_r == ST_IDLE) && div_req && !flush_req && !rst;
    assign div_annul = (state_r != ST_IDLE) && flush_req && !rst;
    assign div_done  = (state_r == ST_DIV_DONE) && !rst;
    assign div_busy  = (state_r == ST_DIV_RUN) && !rst;

endmodule

// File: rtl/suu_pipe_ctrl.sv
// Pipeline stall/flush controller: priority mux of flush, MEM, EX and ID
// hazards around the divide sequencer, producing the per-stage hold vector.
module suu_pipe_ctrl
    import suu_pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_stall_req,
    input  logic       ex_div_req,
    input  logic       mem_stall_req,
    input  logic       exc_flush_req,
    output logic [5:0] stall,
    output logic       flush,
    output logic       div_start,
    output logic       div_annul,
    output logic       div_done,
    output logic       div_busy
);

    div_state_e  div_state_s;
    logic        ex_stall_s;
    logic [5:0]  stall_s;
    logic        flush_s;

    suu_div_seq #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_seq (
        .clk       (clk),
        .rst       (rst),
        .div_req   (ex_div_req),
        .flush_req (exc_flush_req),
        .hold_ex   (stall_s[STG_EX]),
        .state     (div_state_s),
        .div_start (div_start),
        .div_annul (div_annul),
        .div_done  (div_done),
        .div_busy  (div_busy)
    );

    // A running divide holds EX only outside reset; a new request holds it immediately.
    assign ex_stall_s = ((div_state_s == ST_IDLE) && ex_div_req) ||
                        ((div_state_s == ST_DIV_RUN) && !rst);

    // Hazard priority: flush, then MEM, then EX, then ID.
    always_comb begin
        stall_s = STALL_NONE;
        flush_s = 1'b0;
        if (exc_flush_req) begin
            flush_s = 1'b1;
            stall_s = STALL_NONE;
        end else if (mem_stall_req) begin
            stall_s = STALL_MEM;
        end else if (ex_stall_s) begin
            stall_s = STALL_EX;
        end else if (id_stall_req) begin
            stall_s = STALL_ID;
        end else begin
            stall_s = STALL_NONE;
        end
    end

    assign stall = stall_s;
    assign flush = flush_s;

endmodule

// File: tb/tb_suu_pipe_ctrl.sv
// Directed bench for suu_pipe_ctrl: expected output vectors are queued as each
// step is driven and compared on the following falling edge.
module tb_suu_pipe_ctrl;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_ID   = 6'b000111;
    localparam logic [5:0] S_EX   = 6'b001111;
    localparam logic [5:0] S_MEM  = 6'b011111;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_stall_req;
    logic       ex_div_req;
    logic       mem_stall_req;
    logic       exc_flush_req;
    logic [5:0] stall;
    logic       flush;
    logic       div_start;
    logic       div_annul;
    logic       div_done;
    logic       div_busy;

    logic [10:0] sb_q[$];
    string       tag_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    suu_pipe_ctrl #(
        .DIV_CYCLES (32),
        .CNT_W      (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_stall_req  (id_stall_req),
        .ex_div_req    (ex_div_req),
        .mem_stall_req (mem_stall_req),
        .exc_flush_req (exc_flush_req),
        .stall         (stall),
        .flush         (flush),
        .div_start     (div_start),
        .div_annul     (div_annul),
        .div_done      (div_done),
        .div_busy      (div_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] ev(input logic [5:0] s, input logic f, input logic st,
                                       input logic an, input logic dn, input logic bz);
        return {s, f, st, an, dn, bz};
    endfunction

    task automatic compare();
        logic [10:0] exp_v;
        logic [10:0] obs_v;
        string       t;
        exp_v = sb_q.pop_front();
        t     = tag_q.pop_front();
        obs_v = {stall, flush, div_start, div_annul, div_done, div_busy};
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed={stall,flush,start,annul,done,busy}=%b expected=%b", t, obs_v, exp_v);
        end
    endtask

    task automatic drive(input logic r, input logic i, input logic e, input logic m,
                         input logic x, input logic [10:0] exp_v, input string tag);
        @(posedge clk);
        #1;
        rst           = r;
        id_stall_req  = i;
        ex_div_req    = e;
        mem_stall_req = m;
        exc_flush_req = x;
        sb_q.push_back(exp_v);
        tag_q.push_back(tag);
        @(negedge clk);
        compare();
    endtask

    task automatic check_cnt(input logic [5:0] exp_c, input string tag);
        vectors++;
        assert (dut.u_div_seq.cnt_r === exp_c) else begin
            miscompares++;
            $error("FAIL %s observed cnt=%0d expected=%0d", tag, dut.u_div_seq.cnt_r, exp_c);
        end
    endtask

    initial begin
        rst           = 1'b1;
        id_stall_req  = 1'b0;
        ex_div_req    = 1'b0;
        mem_stall_req = 1'b0;
        exc_flush_req = 1'b0;

        // Reset and quiet idle.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ev(S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "reset0");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ev(S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "reset1");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "post_reset");
        check_cnt(6'd0, "cnt_after_reset");

        // Single-cycle load-use stall.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ev(S_ID, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "id_stall");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "id_release");

        // Plain divide: start, 32 run cycles, done, idle.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ev(S_EX, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "div_start");
        for (int k = 1; k <= 32; k++) begin
            drive(1'b0, (k == 5) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0,
                  ev(S_EX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), (k == 5) ? "div_run_with_id" : "div_run");
            if (k == 1) check_cnt(6'd31, "cnt_first_run");
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ev(S_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "div_done");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "div_idle");

        // Divide overlapped by a MEM stall from T+30 to T+40.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ev(S_EX, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "mdiv_start");
        for (int k = 1; k <= 29; k++)
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ev(S_EX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "mdiv_run");
        for (int k = 30; k <= 32; k++)
            drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ev(S_MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "mdiv_run_mem");
        for (int k = 33; k <= 40; k++)
            drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ev(S_MEM, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "mdiv_done_held");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ev(S_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "mdiv_release");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "mdiv_idle");

        // Exception flush at T+10 of a divide.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ev(S_EX, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "fdiv_start");
        for (int k = 1; k <= 9; k++)
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ev(S_EX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "fdiv_run");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ev(S_NONE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1), "fdiv_flush");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "fdiv_idle");
        check_cnt(6'd0, "cnt_after_flush");

        // Flush and start in the same idle cycle.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ev(S_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "flush_vs_start");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "flush_vs_start_idle");

        // Priority corners.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ev(S_MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "mem_over_id");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, ev(S_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "flush_over_mem");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "prio_idle");

        // Reset at T+5 of a divide.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ev(S_EX, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "rdiv_start");
        for (int k = 1; k <= 4; k++)
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ev(S_EX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "rdiv_run");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ev(S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rdiv_reset");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rdiv_after");
        check_cnt(6'd0, "cnt_after_reset_mid_div");
        for (int k = 7; k <= 40; k++)
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rdiv_no_done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
